// File: rtl/package_sorter_param.sv
// package_sorter_param: weigh-station package sorter.
// Classifies the scale reading into NUM_GRP weight groups using run-time
// programmable inclusive upper bounds. An item is counted once per placement,
// and only after its group has been stable for SETTLE consecutive samples.
// Per-group and total counters saturate. A sticky flag marks each group
// counter that has saturated.
module package_sorter_param #(
  parameter int WEIGHT_W = 12,
  parameter int NUM_GRP  = 6,
  parameter int CNT_W    = 8,
  parameter int SETTLE   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WEIGHT_W-1:0]      weight,
  input  logic                     cfg_we,
  input  logic [2:0]               cfg_idx,
  input  logic [WEIGHT_W-1:0]      cfg_data,
  input  logic                     clear,
  output logic [2:0]               cur_grp,
  output logic                     item_valid,
  output logic [2:0]               item_grp,
  output logic [NUM_GRP*CNT_W-1:0] grp_count,
  output logic [NUM_GRP-1:0]       grp_sat,
  output logic [CNT_W-1:0]         total,
  output logic                     cfg_rej,
  output logic                     busy
);

  localparam int               NUM_THR   = NUM_GRP - 1;
  localparam logic [2:0]       GRP_LAST  = 3'(NUM_GRP);
  localparam logic [2:0]       IDX_MAX   = 3'(NUM_GRP - 2);
  localparam logic [3:0]       SETTLE_N  = 4'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COUNTED = 2'd2
  } state_t;

  // Default upper bound for threshold idx; unused slots accept everything.
  function automatic logic [WEIGHT_W-1:0] thr_default(input int idx);
    logic [WEIGHT_W-1:0] v;
    case (idx)
      0:       v = WEIGHT_W'(32'd250);
      1:       v = WEIGHT_W'(32'd500);
      2:       v = WEIGHT_W'(32'd750);
      3:       v = WEIGHT_W'(32'd1500);
      4:       v = WEIGHT_W'(32'd2000);
      default: v = '1;
    endcase
    return v;
  endfunction

  // Saturating increment of a counter value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  // A counter reaches its maximum on this increment (or is already there).
  function automatic logic hits_max(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) || (v == (CNT_MAX - CNT_ONE));
  endfunction

  logic [WEIGHT_W-1:0] thr [NUM_THR];
  logic [CNT_W-1:0]    cnt [NUM_GRP];
  state_t              state;
  logic [2:0]          hgrp;
  logic [3:0]          stab;
  logic                cfg_ok;
  logic                reg_now;
  logic                weight_zero;

  assign weight_zero = (weight == '0);

  // Threshold writes are only safe while nothing sits on the scale.
  assign cfg_ok = cfg_we && (state == ST_IDLE) && weight_zero && (cfg_idx <= IDX_MAX);

  // Classify the live reading: first threshold (lowest index) that holds it wins.
  always_comb begin
    cur_grp = GRP_LAST;
    if (weight_zero) begin
      cur_grp = 3'd0;
    end else begin
      for (int i = NUM_THR - 1; i >= 0; i--) begin
        if (weight <= thr[i]) begin
          cur_grp = 3'(i + 1);
        end
      end
    end
  end

  // Decide whether the current edge registers an item.
  always_comb begin
    reg_now = 1'b0;
    case (state)
      ST_IDLE: begin
        reg_now = !weight_zero && (SETTLE_N == 4'd1);
      end
      ST_SETTLE: begin
        reg_now = !weight_zero && (cur_grp == hgrp) && ((stab + 4'd1) == SETTLE_N);
      end
      default: begin
        reg_now = 1'b0;
      end
    endcase
  end

  // Threshold register file, reloaded with defaults on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_THR; i++) begin
        thr[i] <= thr_default(i);
      end
    end else begin
      for (int i = 0; i < NUM_THR; i++) begin
        if (cfg_ok && (cfg_idx == 3'(i))) begin
          thr[i] <= cfg_data;
        end
      end
    end
  end

  // Flag a dropped threshold write one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cfg_rej <= 1'b0;
    end else begin
      cfg_rej <= cfg_we && !cfg_ok;
    end
  end

  // Item detection FSM with registered busy / item_valid / item_grp.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      hgrp       <= 3'd0;
      stab       <= 4'd0;
      busy       <= 1'b0;
      item_valid <= 1'b0;
      item_grp   <= 3'd0;
    end else begin
      item_valid <= reg_now;
      if (reg_now) begin
        // cur_grp equals hgrp whenever a SETTLE-state registration fires.
        item_grp <= cur_grp;
      end
      case (state)
        ST_IDLE: begin
          if (!weight_zero) begin
            hgrp  <= cur_grp;
            stab  <= 4'd1;
            busy  <= 1'b1;
            state <= reg_now ? ST_COUNTED : ST_SETTLE;
          end else begin
            busy  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (weight_zero) begin
            // Reading vanished before settling: a glitch, not an item.
            state <= ST_IDLE;
            stab  <= 4'd0;
            busy  <= 1'b0;
          end else if (cur_grp != hgrp) begin
            hgrp  <= cur_grp;
            stab  <= 4'd1;
            busy  <= 1'b1;
          end else begin
            stab  <= stab + 4'd1;
            busy  <= 1'b1;
            if (reg_now) begin
              state <= ST_COUNTED;
            end
          end
        end
        ST_COUNTED: begin
          if (weight_zero) begin
            state <= ST_IDLE;
            stab  <= 4'd0;
            busy  <= 1'b0;
          end else begin
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          stab  <= 4'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Per-group counters and sticky saturation flags; clear beats registration.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int g = 0; g < NUM_GRP; g++) begin
        cnt[g] <= '0;
      end
      grp_sat <= '0;
    end else if (clear) begin
      for (int g = 0; g < NUM_GRP; g++) begin
        cnt[g] <= '0;
      end
      grp_sat <= '0;
    end else if (reg_now) begin
      for (int g = 0; g < NUM_GRP; g++) begin
        if (cur_grp == 3'(g + 1)) begin
          cnt[g] <= sat_inc(cnt[g]);
          if (hits_max(cnt[g])) begin
            grp_sat[g] <= 1'b1;
          end
        end
      end
    end
  end

  // Total item counter, saturating; clear beats registration.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      total <= '0;
    end else if (clear) begin
      total <= '0;
    end else if (reg_now) begin
      total <= sat_inc(total);
    end
  end

  // Pack the counters: group g+1 lives in slice [(g+1)*CNT_W-1 -: CNT_W].
  always_comb begin
    grp_count = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      grp_count[g*CNT_W +: CNT_W] = cnt[g];
    end
  end

endmodule

// File: tb/tb_package_sorter_param.sv
// Testbench for package_sorter_param: directed stimulus, a run-length
// reference model checked every cycle, plus hand-computed literal checks.
module tb_package_sorter_param;

  localparam int WW = 12;
  localparam int NG = 6;
  localparam int CW = 4;
  localparam int ST = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [WW-1:0]  weight;
  logic           cfg_we;
  logic [2:0]     cfg_idx;
  logic [WW-1:0]  cfg_data;
  logic           clear;
  logic [2:0]     cur_grp;
  logic           item_valid;
  logic [2:0]     item_grp;
  logic [NG*CW-1:0] grp_count;
  logic [NG-1:0]  grp_sat;
  logic [CW-1:0]  total;
  logic           cfg_rej;
  logic           busy;

  package_sorter_param #(
    .WEIGHT_W(WW), .NUM_GRP(NG), .CNT_W(CW), .SETTLE(ST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .weight(weight), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .clear(clear),
    .cur_grp(cur_grp), .item_valid(item_valid), .item_grp(item_grp),
    .grp_count(grp_count), .grp_sat(grp_sat), .total(total),
    .cfg_rej(cfg_rej), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Reference model state
  int m_thr [NG-1];
  int m_cnt [NG];
  bit m_sat [NG];
  int m_total, m_igrp, m_run, m_grp;
  bit m_valid, m_rej, m_busy, m_done;

  function automatic int mclass(input int w);
    if (w == 0) return 0;
    for (int i = 0; i < NG - 1; i++) begin
      if (w <= m_thr[i]) return i + 1;
    end
    return NG;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: a reading counts once it has shown the same nonzero group on ST
  // consecutive edges, and only once per stretch of nonzero readings.
  always @(posedge clk) begin
    int g;
    bit fire;
    bit acc;
    started = 1'b1;
    m_valid = 1'b0;
    m_rej = 1'b0;
    if (!reset_n) begin
      m_thr[0] = 250; m_thr[1] = 500; m_thr[2] = 750; m_thr[3] = 1500; m_thr[4] = 2000;
      for (int i = 0; i < NG; i++) begin m_cnt[i] = 0; m_sat[i] = 1'b0; end
      m_total = 0; m_igrp = 0; m_run = 0; m_grp = 0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      g = mclass(int'(weight));
      acc = cfg_we && !m_busy && (weight == 0) && (cfg_idx <= 3'(NG - 2));
      if (cfg_we && !acc) m_rej = 1'b1;
      if (acc) m_thr[cfg_idx] = int'(cfg_data);
      fire = 1'b0;
      if (weight == 0) begin
        m_run = 0; m_done = 1'b0;
      end else if (!m_done) begin
        if (m_run != 0 && g == m_grp) m_run++;
        else begin m_run = 1; m_grp = g; end
        if (m_run == ST) begin fire = 1'b1; m_done = 1'b1; end
      end
      m_busy = (weight != 0);
      if (fire) begin m_valid = 1'b1; m_igrp = m_grp; end
      if (clear) begin
        for (int i = 0; i < NG; i++) begin m_cnt[i] = 0; m_sat[i] = 1'b0; end
        m_total = 0;
      end else if (fire) begin
        if (m_cnt[m_grp-1] < CMAX) m_cnt[m_grp-1]++;
        if (m_cnt[m_grp-1] == CMAX) m_sat[m_grp-1] = 1'b1;
        if (m_total < CMAX) m_total++;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    logic [NG*CW-1:0] ec;
    logic [NG-1:0] es;
    if (started) begin
      for (int i = 0; i < NG; i++) begin
        ec[i*CW +: CW] = CW'(m_cnt[i]);
        es[i] = m_sat[i];
      end
      check("cmp_cur_grp", 32'(cur_grp), 32'(mclass(int'(weight))));
      check("cmp_item_valid", 32'(item_valid), 32'(m_valid));
      check("cmp_item_grp", 32'(item_grp), 32'(m_igrp));
      check("cmp_grp_count", 32'(grp_count), 32'(ec));
      check("cmp_grp_sat", 32'(grp_sat), 32'(es));
      check("cmp_total", 32'(total), 32'(m_total));
      check("cmp_cfg_rej", 32'(cfg_rej), 32'(m_rej));
      check("cmp_busy", 32'(busy), 32'(m_busy));
    end
  end

  initial begin
    int bw [5];
    bw[0] = 250; bw[1] = 251; bw[2] = 2000; bw[3] = 2001; bw[4] = 4095;
    reset_n = 1'b0; weight = '0; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_data = '0; clear = 1'b0;
    repeat (3) cyc();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_total", 32'(total), 32'd0);
    check("rst_counts", 32'(grp_count), 32'd0);
    reset_n = 1'b1;

    // Basic item
    weight = 12'd300; repeat (3) cyc(); weight = '0; cyc();
    check("t1_item_grp", 32'(item_grp), 32'd2);
    check("t1_grp2", 32'(grp_count[7:4]), 32'd1);
    check("t1_total", 32'(total), 32'd1);

    // Glitch, then a group change before settling
    weight = 12'd100; cyc(); weight = '0; cyc();
    check("t2_glitch_total", 32'(total), 32'd1);
    weight = 12'd100; cyc(); weight = 12'd1800; cyc(); cyc();
    check("t2_valid", 32'(item_valid), 32'd1);
    check("t2_item_grp", 32'(item_grp), 32'd5);
    weight = '0; cyc();
    check("t2_total", 32'(total), 32'd2);

    // Boundaries
    for (int i = 0; i < 5; i++) begin
      weight = WW'(bw[i]); repeat (3) cyc(); weight = '0; cyc();
    end
    check("t3_grp1", 32'(grp_count[3:0]), 32'd1);
    check("t3_grp2", 32'(grp_count[7:4]), 32'd2);
    check("t3_grp5", 32'(grp_count[19:16]), 32'd2);
    check("t3_grp6", 32'(grp_count[23:20]), 32'd2);
    check("t3_total", 32'(total), 32'd7);
    clear = 1'b1; cyc(); clear = 1'b0;
    check("t3_clear_total", 32'(total), 32'd0);

    // Saturation at minimum item period
    for (int i = 0; i < 17; i++) begin
      weight = 12'd600; repeat (2) cyc(); weight = '0; cyc();
    end
    check("t4_grp3", 32'(grp_count[11:8]), 32'd15);
    check("t4_sat3", 32'(grp_sat[2]), 32'd1);
    check("t4_total", 32'(total), 32'd15);
    clear = 1'b1; cyc(); clear = 1'b0;
    check("t4_clr_counts", 32'(grp_count), 32'd0);
    check("t4_clr_sat", 32'(grp_sat), 32'd0);

    // Threshold programming
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_data = 12'd100; cyc(); cfg_we = 1'b0;
    check("t5_wr_ok_rej", 32'(cfg_rej), 32'd0);
    weight = 12'd150; #1;
    check("t5_cur_grp", 32'(cur_grp), 32'd2);
    repeat (2) cyc();
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_data = 12'd300; cyc(); cfg_we = 1'b0;
    check("t5_busy_rej", 32'(cfg_rej), 32'd1);
    weight = '0; cyc();
    weight = 12'd400; #1;
    check("t5_thr_kept", 32'(cur_grp), 32'd2);
    weight = '0;
    cfg_we = 1'b1; cfg_idx = 3'd5; cfg_data = 12'd7; cyc(); cfg_we = 1'b0;
    check("t5_idx_rej", 32'(cfg_rej), 32'd1);
    cyc();
    check("t5_rej_pulse", 32'(cfg_rej), 32'd0);

    // Reset mid-item overrides clear and cfg writes
    weight = 12'd600; cyc();
    reset_n = 1'b0; cfg_we = 1'b1; cfg_idx = 3'd1; cfg_data = 12'd50; clear = 1'b1; cyc();
    check("t6_rst_valid", 32'(item_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_total", 32'(total), 32'd0);
    reset_n = 1'b1; cfg_we = 1'b0; clear = 1'b0; weight = 12'd150; #1;
    check("t6_thr_default", 32'(cur_grp), 32'd1);
    weight = '0; cyc();

    // Clear on the registering edge
    weight = 12'd600; cyc(); clear = 1'b1; cyc(); clear = 1'b0;
    check("t6_clr_valid", 32'(item_valid), 32'd1);
    check("t6_clr_grp", 32'(item_grp), 32'd3);
    check("t6_clr_total", 32'(total), 32'd0);
    check("t6_clr_counts", 32'(grp_count), 32'd0);
    weight = '0; repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
